// File: rtl/if_prefetch_if.sv
// if_prefetch_if: pipelined Avalon-MM read bus between the fetch stage (master) and instruction memory (slave).
interface if_prefetch_if #(
    parameter int XLEN = 32
);
    logic            read;
    logic [XLEN-1:0] address;
    logic [3:0]      byte_enable;
    logic            waitrequest;
    logic [XLEN-1:0] readdata;
    logic            readdatavalid;

    modport master (
        output read, address, byte_enable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byte_enable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch stage with a prefetch FIFO and multiple outstanding pipelined Avalon reads.
// Define IF_PREFETCH_BYPASS_EN to present a response to ID in its arrival cycle when the FIFO is empty.
module if_prefetch #(
    parameter int              XLEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall,
    input  logic            branch_take,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_pc,
    if_prefetch_if.master   ibus,
    output logic            if2id_valid,
    output logic [XLEN-1:0] if2id_pc,
    output logic [XLEN-1:0] if2id_instruction
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

    logic [OW-1:0]   outstanding, drop, out_n, drop_n;
    logic [CW-1:0]   count, count_n;
    logic [AW-1:0]   wp, rp;
    logic [TW-1:0]   tw, tr;
    logic [XLEN-1:0] fetch_pc, base, target;
    logic [XLEN-1:0] tag [MAX_OUTSTANDING];
    logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_ins [FIFO_DEPTH];
    logic accept, hold, resp, dropping, redirect, live, empty, push, pop, launch;
`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;
`endif

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return p == TW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    assign ibus.byte_enable = 4'b1111;

    always_comb begin
        accept   = ibus.read & ~ibus.waitrequest;
        hold     = ibus.read & ibus.waitrequest;
        // a pulse with nothing outstanding belongs to a read issued before reset
        resp     = ibus.readdatavalid & (outstanding != '0);
        dropping = resp & (drop != '0);
        redirect = trap_take | branch_take;
        target   = trap_take ? trap_pc : branch_pc;
        live     = resp & ~dropping & ~redirect;
        empty    = count == '0;
        pop      = ~empty & ~if_stall;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass   = live & empty;
        push     = live & (~bypass | if_stall);
`else
        push     = live;
`endif
        out_n    = outstanding + OW'(accept) - OW'(resp);
        // a request still held under waitrequest will complete later, so it is dropped as well
        drop_n   = redirect ? out_n + OW'(hold) : drop - OW'(dropping);
        count_n  = redirect ? '0 : count + CW'(push) - CW'(pop);
        base     = redirect ? target : fetch_pc;
        launch   = ~hold & (out_n < OW'(MAX_OUTSTANDING)) &
                   (SW'(count_n) + SW'(out_n) < SW'(FIFO_DEPTH) + SW'(drop_n));
    end

`ifdef IF_PREFETCH_BYPASS_EN
    assign if2id_valid       = ~empty | bypass;
    assign if2id_pc          = bypass ? tag[tr] : fifo_pc[rp];
    assign if2id_instruction = bypass ? ibus.readdata : fifo_ins[rp];
`else
    assign if2id_valid       = ~empty;
    assign if2id_pc          = fifo_pc[rp];
    assign if2id_instruction = fifo_ins[rp];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding  <= '0;
            drop         <= '0;
            count        <= '0;
            wp           <= '0;
            rp           <= '0;
            tw           <= '0;
            tr           <= '0;
            fetch_pc     <= RESET_PC;
            ibus.read    <= 1'b0;
            ibus.address <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]  <= '0;
                fifo_ins[i] <= '0;
            end
        end else begin
            outstanding <= out_n;
            drop        <= drop_n;
            count       <= count_n;
            fetch_pc    <= launch ? base + XLEN'(4) : base;
            ibus.read   <= hold | launch;
            if (launch) ibus.address <= base;
            if (accept) begin
                tag[tw] <= ibus.address;
                tw      <= tag_next(tw);
            end
            if (resp) tr <= tag_next(tr);
            if (push) begin
                fifo_pc[wp]  <= tag[tr];
                fifo_ins[wp] <= ibus.readdata;
                wp           <= wp + 1'b1;
            end
            rp <= redirect ? wp : rp + AW'(pop);
        end
    end
endmodule
